// File: rtl/stepper_onehot_param.sv
// ---------------------------------------------------------------------------
// stepper_onehot_param
//
// Purpose:
//   N-position circular step sequencer with a one-hot decoded output. A
//   programmable prescaler sets the advance rate. Direction is selectable
//   (up/down). The position can be loaded directly. Two modes are offered:
//   free-running, and one-shot, which runs a single revolution and stops.
//
// Parameters:
//   N      number of positions / width of the one-hot output (N >= 2)
//   DIV_W  width of the prescaler divisor (DIV_W >= 1)
//   PW     derived position width, max(1, clog2(N))
//
// Ports:
//   i_clk       rising-edge clock
//   i_rst       synchronous active-high reset
//   i_en        advance enable; low freezes both prescaler and position
//   i_dir       0 = count up, 1 = count down
//   i_oneshot   0 = free-running, 1 = single-revolution mode
//   i_start     one-shot launch request, sampled every cycle
//   i_load      synchronous position load (wins over an advance)
//   i_load_pos  load value, clamped to N-1
//   i_div       prescaler divisor: one advance every i_div+1 enabled cycles
//   o_step      one-hot decode of the position register
//   o_pos       current position, 0..N-1
//   o_wrap      one-cycle pulse after an advance that wraps N-1 <-> 0
//   o_busy      sequencer is actively advancing
// ---------------------------------------------------------------------------
module stepper_onehot_param #(
  parameter int N     = 29,
  parameter int DIV_W = 8,
  localparam int PW   = (N > 2) ? $clog2(N) : 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_dir,
  input  logic             i_oneshot,
  input  logic             i_start,
  input  logic             i_load,
  input  logic [PW-1:0]    i_load_pos,
  input  logic [DIV_W-1:0] i_div,
  output logic [N-1:0]     o_step,
  output logic [PW-1:0]    o_pos,
  output logic             o_wrap,
  output logic             o_busy
);

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  localparam logic [PW-1:0] LAST_POS = PW'(N - 1);
  localparam logic [N-1:0]  STEP_ONE = {{(N-1){1'b0}}, 1'b1};

  state_t           r_state;
  state_t           w_stateNext;
  logic [PW-1:0]    r_pos;
  logic [DIV_W-1:0] r_pc;
  logic             r_wrap;

  logic             w_allow;
  logic             w_tick;
  logic             w_crossing;
  logic [PW-1:0]    w_posNext;
  logic [PW-1:0]    w_loadPos;

  // Advance qualification and next-position arithmetic.
  // Free-running mode may advance in any state. One-shot mode advances only
  // while in RUN. w_crossing marks the single step of a revolution that
  // wraps between the last position and zero. Only that step raises wrap
  // and ends a one-shot.
  always_comb begin
    w_allow    = !i_oneshot || (r_state == S_RUN);
    w_tick     = i_en && w_allow && (r_pc >= i_div);
    w_crossing = i_dir ? (r_pos == '0) : (r_pos == LAST_POS);
    w_posNext  = r_pos;
    if (i_dir) begin
      w_posNext = w_crossing ? LAST_POS : (r_pos - PW'(1));
    end else begin
      w_posNext = w_crossing ? '0 : (r_pos + PW'(1));
    end
    w_loadPos = (i_load_pos > LAST_POS) ? LAST_POS : i_load_pos;
  end

  // Next-state logic and busy output.
  // Dropping oneshot always sends the FSM back to IDLE, even mid-run.
  // A load discards any coincident tick. The wrapping advance is therefore
  // the only event that ends a one-shot.
  always_comb begin
    w_stateNext = r_state;
    if (!i_oneshot) begin
      w_stateNext = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (i_start) w_stateNext = S_RUN;
        S_RUN:   if (!i_load && w_tick && w_crossing) w_stateNext = S_IDLE;
        default: w_stateNext = S_IDLE;
      endcase
    end
    o_busy = i_oneshot ? (r_state == S_RUN) : i_en;
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Prescaler, position and wrap registers.
  // Priority is reset, then load, then advance. The prescaler restarts from
  // zero on every tick and on every load. Because the comparison is ">=",
  // lowering the divisor below the current count ticks on the next edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pos  <= '0;
      r_pc   <= '0;
      r_wrap <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      if (i_load) begin
        r_pos <= w_loadPos;
        r_pc  <= '0;
      end else if (i_en && w_allow) begin
        if (w_tick) begin
          r_pc   <= '0;
          r_pos  <= w_posNext;
          r_wrap <= w_crossing;
        end else begin
          r_pc <= r_pc + DIV_W'(1);
        end
      end
    end
  end

  // Outputs come straight from the registers. The one-hot step output is a
  // pure decode of the position register, so it adds no latency.
  always_comb begin
    o_pos  = r_pos;
    o_wrap = r_wrap;
    o_step = STEP_ONE << r_pos;
  end

endmodule
